// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file.
// Default geometry and register-index helpers.
package regfile_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  function automatic int aw_of(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits for pending writes.
// A set and a clear of the same register in one cycle resolves to set.
module reg_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = aw_of(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] q_idx1,
  input  logic [AW-1:0] q_idx2,
  output logic          busy1,
  output logic          busy2
);

  logic [NREGS-1:0] busy;

  // set (newer producer) beats clear; r0 never busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < NREGS; i++) begin
        if (set_en && set_idx == AW'(i))
          busy[i] <= 1'b1;
        else if (clr_en && clr_idx == AW'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  assign busy1 = busy[q_idx1];
  assign busy2 = busy[q_idx2];

endmodule

// File: rtl/regfile_sb.sv
// 2R/1W register file with busy scoreboard,
// write-back bypass and a selectable debug tap.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter bit BYPASS  = 1'b1,
  parameter int DBG_RST = 31,
  localparam int AW     = aw_of(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] indata,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            dbg_sel_we,
  input  logic [AW-1:0]   dbg_sel_in,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [AW-1:0] ZIDX = AW'(ZERO_REG);

  logic [XLEN-1:0] rf [NREGS];
  logic [AW-1:0]   dbg_sel;
  logic            fwd1;
  logic            fwd2;
  logic            sb_busy1;
  logic            sb_busy2;

  // architectural array; r0 writes dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        rf[i] <= '0;
    end else if (we && rd != ZIDX) begin
      rf[rd] <= indata;
    end
  end

  // debug tap select register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dbg_sel <= AW'(DBG_RST);
    else if (dbg_sel_we)
      dbg_sel <= dbg_sel_in;
  end

  assign fwd1 = BYPASS && we && rd == rs1;
  assign fwd2 = BYPASS && we && rd == rs2;

  // read ports with write-back forwarding
  always_comb begin
    rv1 = rf[rs1];
    rv2 = rf[rs2];
    if (fwd1) rv1 = indata;
    if (fwd2) rv2 = indata;
    if (rs1 == ZIDX) rv1 = '0;
    if (rs2 == ZIDX) rv2 = '0;
  end

  assign dbg_data = rf[dbg_sel];

  reg_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_en (issue_valid && issue_rd != ZIDX),
    .set_idx(issue_rd),
    .clr_en (we),
    .clr_idx(rd),
    .q_idx1 (rs1),
    .q_idx2 (rs2),
    .busy1  (sb_busy1),
    .busy2  (sb_busy2)
  );

  assign rs1_busy = sb_busy1 && !fwd1;
  assign rs2_busy = sb_busy2 && !fwd2;

endmodule
